// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and the memory stage.
package dmem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;

    // Access-size encoding, taken from instruction[13:12].
    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;

    // Store opcode; the memory stage compares against this to form core_we.
    localparam logic [6:0] S_TYPE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CORE   = 2'd1,
        LOADER = 2'd2
    } owner_e;

    typedef struct packed {
        logic              we;
        logic [SIZE_W-1:0] size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_req_mux.sv
// Owner select of the dmemory request fields and read-data steering.
// Everything is gated by the grants so an ungranted side never reaches memory.
module dmem_req_mux
    import dmem_arbiter_pkg::*;
(
    input  logic              core_gnt_i,
    input  logic              ld_gnt_i,
    input  dmem_req_t         core_req_i,
    input  dmem_req_t         ld_req_i,
    input  logic [DATA_W-1:0] mem_res_i,
    output dmem_req_t         dmem_o,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic [DATA_W-1:0] ld_rdata_o
);

    always_comb begin
        dmem_o = '0;
        if (core_gnt_i) begin
            dmem_o = core_req_i;
        end else if (ld_gnt_i) begin
            dmem_o = ld_req_i;
        end
    end

    assign core_rdata_o = (core_gnt_i && !core_req_i.we) ? mem_res_i : '0;
    assign ld_rdata_o   = (ld_gnt_i && !ld_req_i.we) ? mem_res_i : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (memory stage vs loader) for the single dmemory port.
// Define DMEM_ARB_RR_EN for round-robin tie-break in IDLE; default is core-first.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned BURST_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [SIZE_W-1:0] core_size,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [SIZE_W-1:0] ld_size,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_lock,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              dmem_read_write,
    output logic [SIZE_W-1:0] dmem_access_size,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_data_in,
    input  logic [DATA_W-1:0] dmem_mem_res
);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    owner_e             state_q, state_d;
    logic [BURST_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic               core_first;
    dmem_req_t          core_fields, ld_fields, dmem_sel;

    // Grants are gated by reset so nothing reaches memory in a reset cycle.
    assign core_gnt = !reset && (state_q == CORE) && core_req;
    assign ld_gnt   = !reset && (state_q == LOADER) && ld_req;

    // Beats granted in this burst including the current one, saturating.
    assign cnt_inc = (ld_gnt && (cnt_q < BURST_MAX)) ? cnt_q + BURST_W'(1) : cnt_q;

`ifdef DMEM_ARB_RR_EN
    logic last_ld_q, last_ld_d;

    always_comb begin
        last_ld_d = last_ld_q;
        if (state_q == CORE) begin
            last_ld_d = 1'b0;
        end else if (state_q == LOADER) begin
            last_ld_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_ld_q <= 1'b1;
        end else begin
            last_ld_q <= last_ld_d;
        end
    end

    assign core_first = last_ld_q;
`else
    assign core_first = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (core_req && (!ld_req || core_first)) begin
                    state_d = CORE;
                end else if (ld_req) begin
                    state_d = LOADER;
                end
            end
            CORE: begin
                if (!core_req) begin
                    state_d = ld_req ? LOADER : IDLE;
                end
            end
            LOADER: begin
                // A waiting core bounds the locked burst to MAX_BURST beats.
                if (ld_lock && ld_req && (!core_req || (cnt_inc < BURST_MAX))) begin
                    state_d = LOADER;
                    cnt_d   = cnt_inc;
                end else begin
                    state_d = core_req ? CORE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign core_fields = '{we: core_we, size: core_size, addr: core_addr, wdata: core_wdata};
    assign ld_fields   = '{we: ld_we, size: ld_size, addr: ld_addr, wdata: ld_wdata};

    dmem_req_mux u_mux (
        .core_gnt_i   (core_gnt),
        .ld_gnt_i     (ld_gnt),
        .core_req_i   (core_fields),
        .ld_req_i     (ld_fields),
        .mem_res_i    (dmem_mem_res),
        .dmem_o       (dmem_sel),
        .core_rdata_o (core_rdata),
        .ld_rdata_o   (ld_rdata)
    );

    assign dmem_read_write  = dmem_sel.we;
    assign dmem_access_size = dmem_sel.size;
    assign dmem_address     = dmem_sel.addr;
    assign dmem_data_in     = dmem_sel.wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// checked every cycle against a behavioural ownership/memory model.
module tb_dmem_arbiter;

    localparam int MAXB = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        core_req, core_we, ld_req, ld_we, ld_lock;
    logic [1:0]  core_size, ld_size;
    logic [31:0] core_addr, core_wdata, ld_addr, ld_wdata;
    logic        core_gnt, ld_gnt;
    logic [31:0] core_rdata, ld_rdata;
    logic        dmem_read_write;
    logic [1:0]  dmem_access_size;
    logic [31:0] dmem_address, dmem_data_in, dmem_mem_res;

    always #5 clock = ~clock;

    dmem_arbiter #(.MAX_BURST(8), .BURST_W(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .core_req         (core_req),
        .core_we          (core_we),
        .core_size        (core_size),
        .core_addr        (core_addr),
        .core_wdata       (core_wdata),
        .core_gnt         (core_gnt),
        .core_rdata       (core_rdata),
        .ld_req           (ld_req),
        .ld_we            (ld_we),
        .ld_size          (ld_size),
        .ld_addr          (ld_addr),
        .ld_wdata         (ld_wdata),
        .ld_lock          (ld_lock),
        .ld_gnt           (ld_gnt),
        .ld_rdata         (ld_rdata),
        .dmem_read_write  (dmem_read_write),
        .dmem_access_size (dmem_access_size),
        .dmem_address     (dmem_address),
        .dmem_data_in     (dmem_data_in),
        .dmem_mem_res     (dmem_mem_res)
    );

    // Stand-in dmemory: combinational read, write on the clock edge.
    logic [31:0] mem [0:255];
    assign dmem_mem_res = mem[dmem_address[9:2]];
    always @(posedge clock) if (dmem_read_write) mem[dmem_address[9:2]] <= dmem_data_in;

    // Reference model state: owner 0=none 1=core 2=loader.
    logic [31:0] ref_mem [0:255];
    int m_owner, m_beats, m_last;
    logic        e_cgnt, e_lgnt, e_rw;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata, e_crd, e_lrd;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_beats = 0;
        m_last  = 2;
    endtask

    // Evaluate expected outputs for the current cycle and compare.
    task automatic settle();
        #3;
        e_cgnt = !reset && (m_owner == 1) && core_req;
        e_lgnt = !reset && (m_owner == 2) && ld_req;
        e_rw = 1'b0; e_size = 2'b00; e_addr = 32'h0; e_wdata = 32'h0;
        e_crd = 32'h0; e_lrd = 32'h0;
        if (e_cgnt) begin
            e_rw = core_we; e_size = core_size; e_addr = core_addr; e_wdata = core_wdata;
            if (!core_we) e_crd = ref_mem[core_addr[9:2]];
        end else if (e_lgnt) begin
            e_rw = ld_we; e_size = ld_size; e_addr = ld_addr; e_wdata = ld_wdata;
            if (!ld_we) e_lrd = ref_mem[ld_addr[9:2]];
        end
        chk("core_gnt", 32'(core_gnt), 32'(e_cgnt));
        chk("ld_gnt", 32'(ld_gnt), 32'(e_lgnt));
        chk("dmem_read_write", 32'(dmem_read_write), 32'(e_rw));
        chk("dmem_access_size", 32'(dmem_access_size), 32'(e_size));
        chk("dmem_address", dmem_address, e_addr);
        chk("dmem_data_in", dmem_data_in, e_wdata);
        chk("core_rdata", core_rdata, e_crd);
        chk("ld_rdata", ld_rdata, e_lrd);
    endtask

    // Apply this cycle's effects to the model and move to the next cycle.
    task automatic advance();
        int nxt, done;
        if (reset) begin
            model_reset();
        end else begin
            if (e_rw) ref_mem[e_addr[9:2]] = e_wdata;
            nxt  = m_owner;
            done = 0;
            case (m_owner)
                0: begin
                    if (core_req && ld_req) begin
`ifdef DMEM_ARB_RR_EN
                        nxt = (m_last == 2) ? 1 : 2;
`else
                        nxt = 1;
`endif
                    end else if (core_req) nxt = 1;
                    else if (ld_req) nxt = 2;
                end
                1: if (!core_req) nxt = ld_req ? 2 : 0;
                default: begin
                    done = m_beats + (e_lgnt ? 1 : 0);
                    if (done > MAXB) done = MAXB;
                    if (ld_lock && ld_req && (!core_req || done < MAXB)) nxt = 2;
                    else nxt = core_req ? 1 : 0;
                end
            endcase
            if (m_owner != 0) m_last = m_owner;
            m_beats = (m_owner == 2 && nxt == 2) ? done : 0;
            m_owner = nxt;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    logic [31:0] wd [0:11];
    int k, j, first_l, last_l, first_c, ldbeats, got, gap, last_g;
    int seq[$];
    logic cg, lg;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
            ref_mem[i] = 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
        end
        mem[32'h100 >> 2] = 32'hDEADBEEF; ref_mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h104 >> 2] = 32'hCAFEF00D; ref_mem[32'h104 >> 2] = 32'hCAFEF00D;

        // Reset with both sides requesting.
        reset = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_size = 2'b10; core_addr = 32'h100; core_wdata = 32'h0;
        ld_req = 1'b1; ld_we = 1'b0; ld_size = 2'b10; ld_addr = 32'h104; ld_wdata = 32'h0; ld_lock = 1'b0;
        @(posedge clock);
        #1;
        model_reset();
        settle(); advance();
        settle(); advance();
        reset = 1'b0;
        settle(); chk("release_cycle1_core_gnt", 32'(core_gnt), 32'h0); advance();
        settle();
        chk("release_cycle2_core_gnt", 32'(core_gnt), 32'h1);
        chk("core_load_rdata", core_rdata, 32'hDEADBEEF);
        chk("core_load_ld_rdata", ld_rdata, 32'h0);
        advance();
        core_req = 1'b0;

        got = 0;
        for (int c = 0; c < 6 && got == 0; c++) begin
            settle();
            if (e_lgnt) begin
                chk("ld_load_rdata", ld_rdata, 32'hCAFEF00D);
                got = 1;
            end
            advance();
        end
        chk("ld_load_granted", 32'(got), 32'h1);
        ld_req = 1'b0;

        // Locked loader burst of 12 stores, core idle.
        k = 0; first_l = -1; last_l = -1;
        ld_req = 1'b1; ld_we = 1'b1; ld_lock = 1'b1; ld_addr = 32'h200; ld_wdata = $urandom;
        wd[0] = ld_wdata;
        for (int c = 0; c < 60 && k < 12; c++) begin
            settle();
            lg = e_lgnt;
            if (lg) begin
                if (first_l < 0) first_l = cyc;
                last_l = cyc;
                k++;
            end
            advance();
            if (lg) begin
                if (k < 12) begin
                    ld_addr = 32'h200 + 32'(4 * k);
                    ld_wdata = $urandom;
                    wd[k] = ld_wdata;
                end else begin
                    ld_req = 1'b0; ld_lock = 1'b0; ld_we = 1'b0;
                end
            end
        end
        chk("burst12_beats", 32'(k), 32'd12);
        chk("burst12_span", 32'(last_l - first_l), 32'd11);

        // Core reads the burst back.
        j = 0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h200;
        for (int c = 0; c < 80 && j < 12; c++) begin
            settle();
            cg = e_cgnt;
            if (cg) begin
                chk("readback_data", core_rdata, wd[j]);
                j++;
            end
            advance();
            if (cg) begin
                if (j < 12) core_addr = 32'h200 + 32'(4 * j);
                else core_req = 1'b0;
            end
        end
        chk("readback_count", 32'(j), 32'd12);

        // Locked burst with the core requesting from beat 3.
        ldbeats = 0; first_c = -1; last_l = -1;
        ld_req = 1'b1; ld_we = 1'b1; ld_lock = 1'b1; ld_addr = 32'h280; ld_wdata = $urandom;
        core_we = 1'b0; core_addr = 32'h100;
        for (int c = 0; c < 60 && first_c < 0; c++) begin
            settle();
            lg = e_lgnt;
            if (lg) begin ldbeats++; last_l = cyc; end
            if (e_cgnt) first_c = cyc;
            advance();
            if (lg) begin ld_addr = 32'h280 + 32'(4 * ldbeats); ld_wdata = $urandom; end
            if (first_c >= 0) core_req = 1'b0;
            else if (ldbeats == 2) core_req = 1'b1;
        end
        chk("capped_loader_beats", 32'(ldbeats), 32'd8);
        chk("handoff_to_core_gap", 32'(first_c - last_l), 32'd1);
        got = 0;
        for (int c = 0; c < 8 && got == 0; c++) begin
            settle();
            got = e_lgnt ? 1 : 0;
            advance();
        end
        chk("loader_resumes", 32'(got), 32'h1);
        ld_req = 1'b0; ld_lock = 1'b0; ld_we = 1'b0;

        // Core store then load back.
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h300; core_wdata = 32'h12345678;
        got = 0;
        for (int c = 0; c < 8 && got == 0; c++) begin
            settle();
            if (e_cgnt) begin
                chk("store_read_write", 32'(dmem_read_write), 32'h1);
                chk("store_core_rdata", core_rdata, 32'h0);
                got = 1;
            end
            advance();
        end
        chk("store_granted", 32'(got), 32'h1);
        core_req = 1'b0; core_we = 1'b0;
        settle(); chk("store_single_cycle", 32'(dmem_read_write), 32'h0); advance();
        core_req = 1'b1;
        got = 0;
        for (int c = 0; c < 8 && got == 0; c++) begin
            settle();
            if (e_cgnt) begin
                chk("store_readback", core_rdata, 32'h12345678);
                got = 1;
            end
            advance();
        end
        chk("load_granted", 32'(got), 32'h1);
        core_req = 1'b0;

        // Both sides issuing single beats continuously from IDLE.
        reset = 1'b1; settle(); advance(); reset = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
        ld_req = 1'b1; ld_we = 1'b0; ld_lock = 1'b0; ld_addr = 32'h20;
        seq.delete(); gap = 0; last_g = -1;
        for (int c = 0; c < 40 && seq.size() < 8; c++) begin
            settle();
            cg = e_cgnt; lg = e_lgnt;
            if (cg) seq.push_back(1);
            if (lg) seq.push_back(2);
            if ((cg || lg) && last_g >= 0 && (cyc - last_g) > gap) gap = cyc - last_g;
            if (cg || lg) last_g = cyc;
            advance();
            core_req = cg ? 1'b0 : 1'b1;
            ld_req   = lg ? 1'b0 : 1'b1;
        end
        chk("alt_grant_count", 32'(seq.size()), 32'd8);
        for (int i = 0; i < seq.size(); i++) chk("alt_grant_order", 32'(seq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        chk("alt_max_gap", 32'(gap <= 2), 32'h1);
        core_req = 1'b0; ld_req = 1'b0;

        // Random traffic with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            settle();
            cg = e_cgnt; lg = e_lgnt;
            advance();
            if (cg || (!core_req && $urandom_range(0, 2) == 0)) begin
                core_req   = $urandom_range(0, 3) != 0;
                core_we    = $urandom_range(0, 1) == 1;
                core_size  = 2'($urandom_range(0, 2));
                core_addr  = {22'h0, 8'($urandom), 2'b00};
                core_wdata = $urandom;
            end
            if (lg || (!ld_req && $urandom_range(0, 2) == 0)) begin
                ld_req   = $urandom_range(0, 3) != 0;
                ld_we    = $urandom_range(0, 1) == 1;
                ld_lock  = $urandom_range(0, 3) != 0;
                ld_size  = 2'($urandom_range(0, 2));
                ld_addr  = {22'h0, 8'($urandom), 2'b00};
                ld_wdata = $urandom;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single data-memory (`dmemory`) port between the pipeline memory stage and the program loader/debug port. It sits between the memory stage and `dmemory` and owns every drive of `read_write`, `access_size`, `address` and `data_in`. A registered grant state machine sequences ownership. Loader bursts are locked and capped so the core is never starved.

## Interface
Parameters:
- `MAX_BURST`, 8: maximum consecutive loader beats while the core is requesting.
- `BURST_W`, 4: width of the burst counter; must satisfy 2^BURST_W > MAX_BURST.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `core_req`  in  1  memory-stage request, held until granted.
- `core_we`  in  1  1 = store (S-type), 0 = load.
- `core_size`  in  2  access size, instruction[13:12] encoding.
- `core_addr`  in  32  byte address (ALU result).
- `core_wdata`  in  32  store data (rs2).
- `core_gnt`  out  1  transfer occurs this cycle.
- `core_rdata`  out  32  load data, valid when `core_gnt && !core_we`; 0 otherwise.
- `ld_req`, `ld_we`, `ld_size`[2], `ld_addr`[32], `ld_wdata`[32]  in  loader equivalents.
- `ld_lock`  in  1  loader requests to keep ownership after the current beat.
- `ld_gnt`  out  1  loader transfer this cycle.
- `ld_rdata`  out  32  loader load data, same rule as `core_rdata`.
- `dmem_read_write`  out  1  to `dmemory`; 1 = write.
- `dmem_access_size`  out  2  to `dmemory`.
- `dmem_address`  out  32  to `dmemory`.
- `dmem_data_in`  out  32  to `dmemory`.
- `dmem_mem_res`  in  32  `dmemory` read data, combinational with respect to address.

## Operation
- State machine states: IDLE, CORE, LOADER. The state register is the owner.
- IDLE:
  - `core_req` → CORE.
  - else `ld_req` → LOADER.
  - Without the `_EN` feature (see Configuration), the core wins a simultaneous request.
- CORE:
  - One beat per cycle while `core_req`. `core_gnt` = `core_req` combinationally from state.
  - On a cycle with `!core_req`: go to LOADER if `ld_req`, else IDLE.
- LOADER:
  - `ld_gnt` = `ld_req`. The burst counter increments on each granted beat.
  - Stay in LOADER if `ld_lock && ld_req` and (`!core_req` or count < `MAX_BURST`).
  - Otherwise go to CORE if `core_req`, else IDLE.
  - The counter clears on entry to LOADER.
- Mux: the `dmem_*` outputs carry the owner's fields. `dmem_read_write` = owner_we && owner_gnt, so a write is never issued without a grant.
- With no grant, the `dmem_*` outputs are 0.
- rdata: `dmem_mem_res` is routed to the granted requester on a load. The other requester's rdata is 0, and so is the granted requester's on a write.
- The burst counter saturates at `MAX_BURST`; it never wraps.

## Timing
- Grant latency: a request made from IDLE is granted the next cycle. In CORE/LOADER with the matching request, the grant is in the same cycle (zero added latency for back-to-back beats).
- A handoff between owners costs exactly one cycle with no grant to the waiting side. There is no idle bubble when the other side is already requesting.
- A write commits at the clock edge ending the granted cycle. Read data is valid in the granted cycle.
- A requester drops `req` only after a cycle with `gnt`. Inputs must be stable while `req && !gnt`.
- Reset: state = IDLE, counter = 0. All outputs are 0 in the cycle after reset asserts and while it is held.
- Reset mid-burst aborts ownership with no write issued in the reset cycles.
- Reset has priority over all transitions.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin in IDLE. A one-bit `last_owner` register (reset = LOADER) gives the core the first simultaneous tie, then alternates.
- Undefined: fixed priority, core first; no `last_owner` register. `MAX_BURST` capping applies in both builds.

## Structure
- Shared package:
  - owner state enum (IDLE/CORE/LOADER);
  - access-size constants (byte/half/word = 2'b00/01/10);
  - `S_TYPE` opcode constant, reused by the memory stage to form `core_we`.
- One natural sub-module: `dmem_req_mux`, the combinational owner-select of the `dmem_*` fields and rdata steering.
- The FSM and counter stay in `dmem_arbiter`.

## Test plan
- Reset with both req=1 → all outputs 0 during reset. Core granted in the second cycle after release (fixed priority build).
- Core load: addr 0x100, size 2'b10, memory holds 0xDEADBEEF → `core_gnt` = 1 and `core_rdata` = 0xDEADBEEF in the same cycle; `ld_rdata` = 0.
- Loader locked burst of 12 stores to 0x200..0x22C, core idle → 12 consecutive `ld_gnt`, no bubble. Reading back returns the written data.
- Loader locked burst with core requesting from beat 3 → exactly 8 loader beats, one handoff cycle, then `core_gnt`.
- Core store (`core_we` = 1) of 0x12345678 → `dmem_read_write` = 1 for one cycle and `core_rdata` = 0. A subsequent load returns 0x12345678.
- `DMEM_ARB_RR_EN` build, both sides issuing single-beat requests continuously from IDLE → grants alternate core, loader, core, …; neither side waits more than one handoff.
